execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 131 +++++++++++++
 tb/tb_execute_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage pipeline: ALU, slt/beq compare, memory address generation,
// and a small flush FSM that squashes the two wrong-path instructions behind a taken beq.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] DX_rtData,
  input  logic [31:0] DX_PC,
  input  logic [4:0]  RD,
  input  logic [2:0]  ALUctr,
  input  logic        DX_lwFlag,
  input  logic        DX_swFlag,
  input  logic [2:0]  DX_compareFlag,
  output logic [31:0] XM_ALUout,
  output logic [4:0]  XM_RD,
  output logic        XM_lwFlag,
  output logic        XM_swFlag,
  output logic [2:0]  XM_compareFlag,
  output logic [31:0] XM_swData,
  output logic        XM_branchTaken,
  output logic [31:0] XM_branchTarget
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state, state_next;
  logic [1:0]  flush_cnt, flush_cnt_next;

  logic [31:0] sum, diff;
  logic        is_eq, is_lt;

  logic [31:0] alu_next, sw_data_next, target_next;
  logic [4:0]  rd_next;
  logic        lw_next, sw_next, taken_next;
  logic [2:0]  cmp_next;

  assign sum   = A + B;
  assign diff  = A - B;
  assign is_eq = (A == DX_rtData);
  assign is_lt = ($signed(A) < $signed(B));

  // Memory markers take priority over ALUctr; anything undecodable leaves the bubble defaults.
  always_comb begin
    alu_next       = '0;
    rd_next        = '0;
    lw_next        = 1'b0;
    sw_next        = 1'b0;
    cmp_next       = '0;
    sw_data_next   = '0;
    taken_next     = 1'b0;
    target_next    = '0;
    state_next     = state;
    flush_cnt_next = flush_cnt;

    if (state == FLUSH) begin
      flush_cnt_next = flush_cnt - 2'd1;
      if (flush_cnt <= 2'd1) begin
        flush_cnt_next = '0;
        state_next     = RUN;
      end
    end else if (DX_lwFlag) begin
      alu_next = sum;
      rd_next  = RD;
      lw_next  = 1'b1;
      cmp_next = DX_compareFlag;
    end else if (DX_swFlag) begin
      alu_next     = sum;
      sw_next      = 1'b1;
      sw_data_next = DX_rtData;
      cmp_next     = DX_compareFlag;
    end else begin
      case (ALUctr)
        3'd0: begin
          alu_next = sum;
          rd_next  = RD;
          cmp_next = DX_compareFlag;
        end
        3'd1: begin
          alu_next = diff;
          rd_next  = RD;
          cmp_next = DX_compareFlag;
        end
        3'd2: begin
          if (DX_compareFlag == 3'd0) begin
            alu_next = {31'b0, is_lt};
            rd_next  = RD;
            cmp_next = DX_compareFlag;
          end else if (DX_compareFlag == 3'd1) begin
            alu_next    = {31'b0, is_eq};
            taken_next  = is_eq;
            target_next = DX_PC + {B[29:0], 2'b00};
            cmp_next    = DX_compareFlag;
            if (is_eq) begin
              state_next     = FLUSH;
              flush_cnt_next = 2'd2;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      flush_cnt       <= '0;
      XM_ALUout       <= '0;
      XM_RD           <= '0;
      XM_lwFlag       <= 1'b0;
      XM_swFlag       <= 1'b0;
      XM_compareFlag  <= '0;
      XM_swData       <= '0;
      XM_branchTaken  <= 1'b0;
      XM_branchTarget <= '0;
    end else begin
      state           <= state_next;
      flush_cnt       <= flush_cnt_next;
      XM_ALUout       <= alu_next;
      XM_RD           <= rd_next;
      XM_lwFlag       <= lw_next;
      XM_swFlag       <= sw_next;
      XM_compareFlag  <= cmp_next;
      XM_swData       <= sw_data_next;
      XM_branchTaken  <= taken_next;
      XM_branchTarget <= target_next;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver queues the hand-computed result of every
// cycle it drives, and an independent monitor pops and compares one entry per clock.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic [31:0] a, b, rt_data, pc;
  logic [4:0]  rd;
  logic [2:0]  alu_ctr;
  logic        lw_flag, sw_flag;
  logic [2:0]  cmp_flag;
  logic [31:0] xm_alu_out, xm_sw_data, xm_target;
  logic [4:0]  xm_rd;
  logic        xm_lw, xm_sw, xm_taken;
  logic [2:0]  xm_cmp;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        lw;
    logic        sw;
    logic [2:0]  cmp;
    logic [31:0] sw_data;
    logic        taken;
    logic [31:0] target;
    logic        chk_target;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  execute_stage dut (
    .clk             (clk),
    .rst             (rst),
    .A               (a),
    .B               (b),
    .DX_rtData       (rt_data),
    .DX_PC           (pc),
    .RD              (rd),
    .ALUctr          (alu_ctr),
    .DX_lwFlag       (lw_flag),
    .DX_swFlag       (sw_flag),
    .DX_compareFlag  (cmp_flag),
    .XM_ALUout       (xm_alu_out),
    .XM_RD           (xm_rd),
    .XM_lwFlag       (xm_lw),
    .XM_swFlag       (xm_sw),
    .XM_compareFlag  (xm_cmp),
    .XM_swData       (xm_sw_data),
    .XM_branchTaken  (xm_taken),
    .XM_branchTarget (xm_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] alu, input logic [4:0] r, input logic lw,
                              input logic sw, input logic [2:0] cmp, input logic [31:0] swd,
                              input logic taken, input logic [31:0] target, input logic chk);
    exp_t e;
    e.alu = alu; e.rd = r; e.lw = lw; e.sw = sw; e.cmp = cmp; e.sw_data = swd;
    e.taken = taken; e.target = target; e.chk_target = chk;
    return e;
  endfunction

  function automatic exp_t bubble();
    return mk(32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
  endfunction

  task automatic apply_stimulus(input logic [31:0] ia, input logic [31:0] ib,
                                input logic [31:0] irt, input logic [31:0] ipc,
                                input logic [4:0] ird, input logic [2:0] ictr,
                                input logic ilw, input logic isw, input logic [2:0] icmp,
                                input exp_t e);
    @(negedge clk);
    rst = 1'b0;
    a = ia; b = ib; rt_data = irt; pc = ipc; rd = ird; alu_ctr = ictr;
    lw_flag = ilw; sw_flag = isw; cmp_flag = icmp;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(bubble());
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got %h expected %h", vec_idx, name, act, expv);
    end
  endtask

  // Monitor: one result per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("alu_out", xm_alu_out, e.alu);
        check_output("rd", {27'b0, xm_rd}, {27'b0, e.rd});
        check_output("lw_flag", {31'b0, xm_lw}, {31'b0, e.lw});
        check_output("sw_flag", {31'b0, xm_sw}, {31'b0, e.sw});
        check_output("cmp_flag", {29'b0, xm_cmp}, {29'b0, e.cmp});
        check_output("sw_data", xm_sw_data, e.sw_data);
        check_output("branch_taken", {31'b0, xm_taken}, {31'b0, e.taken});
        if (e.chk_target)
          check_output("branch_target", xm_target, e.target);
        vec_idx++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    a = '0; b = '0; rt_data = '0; pc = '0; rd = '0; alu_ctr = '0;
    lw_flag = 1'b0; sw_flag = 1'b0; cmp_flag = '0;

    reset_cycle();
    reset_cycle();

    // add wraps, sub both signs, slt signed
    apply_stimulus(32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'd5, 3'd0, 1'b0, 1'b0, 3'd0,
                   mk(32'h0, 5'd5, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));
    apply_stimulus(32'd10, 32'd3, 32'h0, 32'h0, 5'd9, 3'd1, 1'b0, 1'b0, 3'd0,
                   mk(32'd7, 5'd9, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));
    apply_stimulus(32'd3, 32'd10, 32'h0, 32'h0, 5'd10, 3'd1, 1'b0, 1'b0, 3'd0,
                   mk(32'hFFFFFFF9, 5'd10, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));
    apply_stimulus(32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 5'd7, 3'd2, 1'b0, 1'b0, 3'd0,
                   mk(32'h1, 5'd7, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));
    apply_stimulus(32'd5, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd8, 3'd2, 1'b0, 1'b0, 3'd0,
                   mk(32'h0, 5'd8, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));

    // lw, sw, reserved opcode
    apply_stimulus(32'h200, 32'h10, 32'h0, 32'h0, 5'd2, 3'd0, 1'b1, 1'b0, 3'd0,
                   mk(32'h210, 5'd2, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));
    apply_stimulus(32'h100, 32'h8, 32'hDEADBEEF, 32'h0, 5'd11, 3'd0, 1'b0, 1'b1, 3'd0,
                   mk(32'h108, 5'd0, 1'b0, 1'b1, 3'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0));
    apply_stimulus(32'h1, 32'h2, 32'h3, 32'h0, 5'd12, 3'd5, 1'b0, 1'b0, 3'd0, bubble());

    // not-taken beq keeps the pipe running
    apply_stimulus(32'd9, 32'd4, 32'd8, 32'h40, 5'd1, 3'd2, 1'b0, 1'b0, 3'd1,
                   mk(32'h0, 5'd0, 1'b0, 1'b0, 3'd1, 32'h0, 1'b0, 32'h50, 1'b1));
    apply_stimulus(32'd1, 32'd1, 32'h0, 32'h0, 5'd13, 3'd0, 1'b0, 1'b0, 3'd0,
                   mk(32'd2, 5'd13, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));

    // taken beq with negative offset, two squashed adds, then a live add
    apply_stimulus(32'd9, 32'hFFFFFFFE, 32'd9, 32'h20, 5'd1, 3'd2, 1'b0, 1'b0, 3'd1,
                   mk(32'h1, 5'd0, 1'b0, 1'b0, 3'd1, 32'h0, 1'b1, 32'h18, 1'b1));
    apply_stimulus(32'd1, 32'd2, 32'h0, 32'h0, 5'd3, 3'd0, 1'b0, 1'b0, 3'd0, bubble());
    apply_stimulus(32'd1, 32'd2, 32'h0, 32'h0, 5'd4, 3'd0, 1'b0, 1'b0, 3'd0, bubble());
    apply_stimulus(32'd4, 32'd5, 32'h0, 32'h0, 5'd6, 3'd0, 1'b0, 1'b0, 3'd0,
                   mk(32'd9, 5'd6, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));

    // back-to-back taken beqs: only the first pulses
    apply_stimulus(32'd7, 32'd1, 32'd7, 32'h100, 5'd0, 3'd2, 1'b0, 1'b0, 3'd1,
                   mk(32'h1, 5'd0, 1'b0, 1'b0, 3'd1, 32'h0, 1'b1, 32'h104, 1'b1));
    apply_stimulus(32'd7, 32'd1, 32'd7, 32'h104, 5'd0, 3'd2, 1'b0, 1'b0, 3'd1, bubble());
    apply_stimulus(32'd2, 32'd2, 32'h0, 32'h0, 5'd14, 3'd0, 1'b0, 1'b0, 3'd0, bubble());
    apply_stimulus(32'd3, 32'd3, 32'h0, 32'h0, 5'd15, 3'd0, 1'b0, 1'b0, 3'd0,
                   mk(32'd6, 5'd15, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));

    // reset in the middle of a flush aborts it
    apply_stimulus(32'h55, 32'd2, 32'h55, 32'h200, 5'd0, 3'd2, 1'b0, 1'b0, 3'd1,
                   mk(32'h1, 5'd0, 1'b0, 1'b0, 3'd1, 32'h0, 1'b1, 32'h208, 1'b1));
    reset_cycle();
    apply_stimulus(32'h10, 32'h20, 32'h0, 32'h0, 5'd6, 3'd0, 1'b0, 1'b0, 3'd0,
                   mk(32'h30, 5'd6, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending results expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
